usb_stream_packetizer: RTL

//  Parametrised full-duplex USB-UART link between the N-channel sample path and the host.
//  - Buffers sample sets in a FIFO and frames each set into 8-bit bytes: framing bit, odd-parity bit, 6 payload bits.
//  - Serialises the bytes 8N1 on tx; decodes host command bytes on rx that start/stop streaming and flush the FIFO.
//  - Sits between the ADC capture block and the USB-UART bridge pins.

---
 rtl/usb_stream_packetizer_if.sv | 24 ++
 rtl/usb_stream_packetizer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_stream_packetizer_if.sv
// rtl/usb_stream_packetizer_if.sv - sample capture and USB-UART link signals of the stream packetizer
interface usb_stream_packetizer_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_WIDTH = 12
);
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_data;
  logic                                 sample_valid;
  logic                                 rx;
  logic                                 tx;
  logic                                 stream_en;
  logic                                 overflow;
  logic                                 rx_error;
  logic                                 busy;

  modport master (
    output sample_data, sample_valid, rx,
    input  tx, stream_en, overflow, rx_error, busy
  );

  modport slave (
    input  sample_data, sample_valid, rx,
    output tx, stream_en, overflow, rx_error, busy
  );
endinterface

// File: rtl/usb_stream_packetizer.sv
// rtl/usb_stream_packetizer.sv - FIFO-buffered sample framer, 8N1 tx serialiser and rx command decoder
// Optional checksum byte per frame: define USB_STREAM_CHECKSUM_EN.
module usb_stream_packetizer #(
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_WIDTH = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int DIVIDER      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  usb_stream_packetizer_if.slave  bus
);
  localparam int SW    = SAMPLE_WIDTH;
  localparam int DW    = NUM_CHANNELS * SW;
  localparam int B     = (SW + 5) / 6;
  localparam int NDATA = NUM_CHANNELS * B;
`ifdef USB_STREAM_CHECKSUM_EN
  localparam int NBYTES = NDATA + 1;
`else
  localparam int NBYTES = NDATA;
`endif
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BIW = $clog2(NBYTES + 1);
  localparam int CW  = $clog2(DIVIDER);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push_req, push, pop, drop, flush;
  logic          stream_en_q, overflow_q, rx_error_q, cmd_valid;
  logic [DW-1:0] frame_q;

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [BIW-1:0] byte_idx;
  logic          tick, last_byte, tx_d, tx_q;
  logic [6*B-1:0] ext;
  logic [5:0]    ck, payload;
  logic [7:0]    tx_byte;
`ifdef USB_STREAM_CHECKSUM_EN
  logic [5:0]    csum;
`endif

  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rcnt;
  logic [2:0]    rbit;
  logic [7:0]    rshift;
  logic          rtick, half_tick, r_shift_en, r_done, r_err;

  assign bus.tx        = tx_q;
  assign bus.stream_en = stream_en_q;
  assign bus.overflow  = overflow_q;
  assign bus.rx_error  = rx_error_q;
  assign bus.busy      = (tx_state != TX_IDLE);

  // FIFO: a pop in the same cycle frees a slot for a push into a full FIFO
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign flush    = cmd_valid & rshift[1];
  assign push_req = bus.sample_valid & stream_en_q;
  assign push     = push_req & (~full | pop) & ~flush;
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.sample_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // The set is captured on pop so a flush or refill cannot disturb the frame in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  frame_q <= '0;
    else if (pop)  frame_q <= mem[rd_ptr[AW-1:0]];
  end

  assign tick      = (div_cnt == CW'(DIVIDER - 1));
  assign last_byte = (byte_idx == BIW'(NBYTES - 1));

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!empty) begin pop = 1'b1; tx_next = TX_LOAD; end
      TX_LOAD:  tx_next = TX_START;
      TX_START: if (tick) tx_next = TX_DATA;
      TX_DATA:  if (tick && bit_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tick) tx_next = last_byte ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_q     <= tx_d;
      if (tx_state == TX_IDLE || tx_state == TX_LOAD || tick) div_cnt <= '0;
      else                                                      div_cnt <= div_cnt + CW'(1);
      if (tx_state == TX_START)         bit_idx <= '0;
      else if (tx_state == TX_DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (tx_state == TX_LOAD)          byte_idx <= '0;
      else if (tx_state == TX_STOP && tick) byte_idx <= byte_idx + BIW'(1);
    end
  end

  // Byte k of the frame: channel (N-1 - k/B), chunk (B-1 - k%B) of the zero-extended sample
  always_comb begin
    ext     = '0;
    ck      = '0;
    payload = '0;
`ifdef USB_STREAM_CHECKSUM_EN
    csum    = '0;
`endif
    for (int i = 0; i < NDATA; i++) begin
      ext          = '0;
      ext[SW-1:0]  = frame_q[(NUM_CHANNELS-1-i/B)*SW +: SW];
      ck           = ext[(B-1-i%B)*6 +: 6];
`ifdef USB_STREAM_CHECKSUM_EN
      csum         = csum ^ ck;
`endif
      if (byte_idx == BIW'(i)) payload = ck;
    end
`ifdef USB_STREAM_CHECKSUM_EN
    if (byte_idx == BIW'(NDATA)) payload = csum;
`endif
  end

  assign tx_byte = {byte_idx != '0, ~^payload, payload};

  always_comb begin
    tx_d = 1'b1;
    case (tx_state)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_byte[bit_idx];
      default:  tx_d = 1'b1;
    endcase
  end

  assign rtick     = (rcnt == CW'(DIVIDER - 1));
  assign half_tick = (rcnt == CW'(DIVIDER/2 - 1));

  always_comb begin
    rx_next    = rx_state;
    r_shift_en = 1'b0;
    r_done     = 1'b0;
    r_err      = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_s2 && rx_s3) rx_next = RX_START;
      RX_START: if (half_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rtick) begin
                  r_shift_en = 1'b1;
                  if (rbit == 3'd7) rx_next = RX_STOP;
                end
      RX_STOP:  if (rtick) begin
                  rx_next = RX_IDLE;
                  r_done  = rx_s2;
                  r_err   = ~rx_s2;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_s3       <= 1'b1;
      rx_state    <= RX_IDLE;
      rcnt        <= '0;
      rbit        <= '0;
      rshift      <= '0;
      cmd_valid   <= 1'b0;
      rx_error_q  <= 1'b0;
      stream_en_q <= 1'b0;
    end else begin
      rx_s1      <= bus.rx;
      rx_s2      <= rx_s1;
      rx_s3      <= rx_s2;
      rx_state   <= rx_next;
      cmd_valid  <= r_done;
      rx_error_q <= r_err;
      if (rx_state == RX_IDLE || rx_next != rx_state || rtick) rcnt <= '0;
      else                                                      rcnt <= rcnt + CW'(1);
      if (rx_state != RX_DATA) rbit <= '0;
      else if (r_shift_en)     rbit <= rbit + 3'd1;
      if (r_shift_en) rshift <= {rx_s2, rshift[7:1]};
      if (cmd_valid)  stream_en_q <= rshift[0];
    end
  end
endmodule
